// File: rtl/dmem_responder.sv
// Single-line write-through buffer between a 32-bit core data port and a
// 256-bit line-oriented backing memory.
// Read hits are served from the buffer.
// Misses fetch the whole line first.
// Every write updates the buffer and then pushes the full line to backing memory.
module dmem_responder (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  dmem_address,
    input  logic [3:0]   dmem_rmask,
    input  logic [3:0]   dmem_wmask,
    input  logic [31:0]  dmem_wdata,
    output logic [31:0]  dmem_rdata,
    output logic         dmem_resp,
    output logic [31:0]  mem_address,
    output logic         mem_read,
    output logic         mem_write,
    input  logic [255:0] mem_rdata,
    output logic [255:0] mem_wdata,
    input  logic         mem_resp
);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, RESP} state_t;

    state_t        state;
    logic [255:0]  line_data;
    logic [26:0]   line_tag;
    logic          line_valid;

    logic          req_wr;
    logic          req_any;
    logic          hit;
    logic [2:0]    word_idx;
    logic [255:0]  hit_merged;
    logic [255:0]  fetch_merged;

    // Extract one 32-bit word from a line.
    function automatic logic [31:0] get_word(input logic [255:0] line, input logic [2:0] idx);
        return line[{idx, 5'b0} +: 32];
    endfunction

    // Overlay the mask-selected store bytes onto one word of a line.
    function automatic logic [255:0] merge_word(input logic [255:0] line, input logic [2:0] idx,
                                                input logic [31:0] wdata, input logic [3:0] wmask);
        logic [255:0] res;
        logic [31:0]  w;
        res = line;
        w   = get_word(line, idx);
        for (int b = 0; b < 4; b++) begin
            if (wmask[b]) w[b*8 +: 8] = wdata[b*8 +: 8];
        end
        res[{idx, 5'b0} +: 32] = w;
        return res;
    endfunction

    // Request decode.
    // A write mask wins over a read mask.
    assign req_wr       = |dmem_wmask;
    assign req_any      = req_wr || (|dmem_rmask);
    assign word_idx     = dmem_address[4:2];
    assign hit          = line_valid && (line_tag == dmem_address[31:5]);
    assign hit_merged   = merge_word(line_data, word_idx, dmem_wdata, dmem_wmask);
    assign fetch_merged = merge_word(mem_rdata, word_idx, dmem_wdata, dmem_wmask);

    // The write line is driven only while a write is outstanding.
    // This keeps the bus at zero when idle.
    assign mem_wdata = mem_write ? line_data : '0;

    // Controller state machine.
    // All handshake outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            line_valid  <= 1'b0;
            dmem_resp   <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            dmem_rdata  <= '0;
            mem_address <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        if (hit) begin
                            if (req_wr) begin
                                line_data   <= hit_merged;
                                dmem_rdata  <= get_word(hit_merged, word_idx);
                                mem_write   <= 1'b1;
                                mem_address <= {line_tag, 5'b0};
                                state       <= WRITE;
                            end else begin
                                dmem_rdata <= get_word(line_data, word_idx);
                                dmem_resp  <= 1'b1;
                                state      <= RESP;
                            end
                        end else begin
                            mem_read    <= 1'b1;
                            mem_address <= {dmem_address[31:5], 5'b0};
                            state       <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (mem_resp) begin
                        mem_read   <= 1'b0;
                        line_tag   <= dmem_address[31:5];
                        line_valid <= 1'b1;
                        if (req_wr) begin
                            // Same line, so mem_address already points at the write target.
                            line_data  <= fetch_merged;
                            dmem_rdata <= get_word(fetch_merged, word_idx);
                            mem_write  <= 1'b1;
                            state      <= WRITE;
                        end else begin
                            line_data   <= mem_rdata;
                            dmem_rdata  <= get_word(mem_rdata, word_idx);
                            dmem_resp   <= 1'b1;
                            mem_address <= '0;
                            state       <= RESP;
                        end
                    end
                end
                WRITE: begin
                    if (mem_resp) begin
                        mem_write   <= 1'b0;
                        mem_address <= '0;
                        dmem_resp   <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    dmem_resp <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
